pwm_ramp_sequencer: RTL and testbench
=====================================

PWM_RAMP_SEQUENCER -- requirements
Module: pwm_ramp_sequencer

Interface
REQ-001 The block SHALL have parameter RETRY_WAIT, default 16, giving the number of CLK cycles the driver is held in reset between fault retries.
REQ-002 CLK  input  1  clock; all logic SHALL be clocked on its rising edge.
REQ-003 RESET_n  input  1  reset, synchronous, active-low.
REQ-004 ENABLE  input  1  run request; level-sensitive.
REQ-005 TARGET_PWM  input  8  requested steady-state duty.
REQ-006 RAMP_STEP  input  4  duty increment per ramp step; value 0 SHALL be treated as 1.
REQ-007 RAMP_CYCLES  input  4  CYCLE pulses per ramp step; value 0 SHALL be treated as 1.
REQ-008 BBM_CFG / PRESCALER_CFG  input  4 / 3  dead-time and prescaler configuration.
REQ-009 RETRY_LIMIT  input  2  number of fault retries allowed before lockout.
REQ-010 CYCLE  input  1  one-CLK pulse from the driver at the end of each PWM period.
REQ-011 FAULT_DETECT  input  1  latched fault flag from the driver.
REQ-012 LIMIT_PWM  input  8  driver count captured at the last I/V limit event (8'hFF = none).
REQ-013 DRV_RESET_n  output  1  synchronous active-low reset to the driver.
REQ-014 PWM / BREAK_BEFORE_MAKE / PRESCALER  output  8 / 4 / 3  driver configuration.
REQ-015 STATE  output  3  current state encoding; READY  output  1; LOCKOUT  output  1.

Function
REQ-016 States and encodings SHALL be: IDLE=0, RAMP=1, RUN=2, FAULT=3, RETRY=4, LOCK=5; all outputs SHALL be registered, and state changes SHALL take effect one CLK after the triggering input is sampled.
REQ-017 IDLE: PWM=0, DRV_RESET_n=0, retry count cleared, BREAK_BEFORE_MAKE<=BBM_CFG and PRESCALER<=PRESCALER_CFG every clock; configuration SHALL be frozen in every other state.
REQ-018 IDLE with ENABLE=1 SHALL transition to RAMP, DRV_RESET_n<=1, PWM=0, ramp counter=0.
REQ-019 RAMP: each CYCLE pulse SHALL increment the ramp counter; when the counter reaches the effective RAMP_CYCLES, PWM<=min(PWM+effective RAMP_STEP, TARGET_PWM), computed 9-bit with no wrap, and the counter SHALL clear.
REQ-020 RAMP with PWM==TARGET_PWM SHALL transition to RUN; TARGET_PWM=0 SHALL enter RUN with PWM=0.
REQ-021 RUN: if TARGET_PWM<PWM, PWM<=TARGET_PWM on the next clock; if TARGET_PWM>PWM, the block SHALL return to RAMP with the counter cleared.
REQ-022 Limit fold-back: in RAMP or RUN, a CYCLE pulse with LIMIT_PWM<PWM SHALL set PWM<=LIMIT_PWM and state RAMP, with the counter cleared.
REQ-023 RUN: the retry count SHALL clear after 16 consecutive CYCLE pulses in RUN; the run counter SHALL restart on leaving RUN.
REQ-024 FAULT_DETECT=1 in RAMP or RUN SHALL transition to FAULT with PWM<=0.
REQ-025 FAULT (one clock): if retry count==RETRY_LIMIT, go to LOCK; otherwise increment the retry count and go to RETRY.
REQ-026 RETRY: DRV_RESET_n=0 for exactly RETRY_WAIT clocks, then the block SHALL enter RAMP with DRV_RESET_n<=1 and PWM=0.
REQ-027 LOCK: DRV_RESET_n=0, PWM=0, LOCKOUT=1; the block SHALL exit to IDLE only when ENABLE=0.
REQ-028 ENABLE=0 in RAMP, RUN, FAULT or RETRY SHALL force IDLE on the next clock.
REQ-029 Priority within one clock SHALL be: ENABLE=0 > FAULT_DETECT > limit fold-back > TARGET decrease > ramp step.
REQ-030 READY SHALL be 1 iff state is RUN; LOCKOUT SHALL be 1 iff state is LOCK.

Reset
REQ-031 With RESET_n=0 at a clock edge: state IDLE, PWM=0, DRV_RESET_n=0, BREAK_BEFORE_MAKE=4'hF, PRESCALER=0, READY=0, LOCKOUT=0, STATE=0, and all counters 0.
REQ-032 Reset asserted mid-ramp or mid-retry SHALL abort immediately to the REQ-031 values, with no partial-state carry-over.

Verification
REQ-033 ENABLE=1, TARGET=40, STEP=8, RAMP_CYCLES=2 -> PWM 0,8,16,24,32,40 changing every 2nd CYCLE; READY=1 when PWM=40.
REQ-034 TARGET=37, STEP=15, RAMP_CYCLES=0 -> PWM 15,30,37 (saturates at target); STEP=0 -> +1 per CYCLE.
REQ-035 In RUN with PWM=200, LIMIT_PWM=90 on a CYCLE pulse -> PWM=90, STATE=RAMP, then ramp back toward 200.
REQ-036 RETRY_LIMIT=1 with FAULT_DETECT held high -> FAULT, RETRY (DRV_RESET_n low for 16 clocks), RAMP, FAULT, LOCK; LOCKOUT=1 until ENABLE=0.
REQ-037 ENABLE=0 and FAULT_DETECT=1 in the same clock during RUN -> IDLE, retry count unchanged at 0.
REQ-038 RESET_n low during RETRY -> all outputs at REQ-031 values on the next clock.

Source files
------------

// File: rtl/pwm_ramp_sequencer_if.sv
// Purpose: bundles the run request, ramp configuration, driver status and
//          driver configuration signals shared by pwm_ramp_sequencer and
//          the PWM driver it supervises.
// Signals:
//   ENABLE, TARGET_PWM, RAMP_STEP, RAMP_CYCLES, BBM_CFG, PRESCALER_CFG,
//   RETRY_LIMIT                 - run request and configuration (to sequencer)
//   CYCLE, FAULT_DETECT, LIMIT_PWM - driver status (to sequencer)
//   DRV_RESET_n, PWM, BREAK_BEFORE_MAKE, PRESCALER - driver control (from sequencer)
//   STATE, READY, LOCKOUT       - sequencer status (from sequencer)
// Modports: master = sequencer side, slave = driver/host side.
interface pwm_ramp_sequencer_if;
   logic       ENABLE;
   logic [7:0] TARGET_PWM;
   logic [3:0] RAMP_STEP;
   logic [3:0] RAMP_CYCLES;
   logic [3:0] BBM_CFG;
   logic [2:0] PRESCALER_CFG;
   logic [1:0] RETRY_LIMIT;
   logic       CYCLE;
   logic       FAULT_DETECT;
   logic [7:0] LIMIT_PWM;
   logic       DRV_RESET_n;
   logic [7:0] PWM;
   logic [3:0] BREAK_BEFORE_MAKE;
   logic [2:0] PRESCALER;
   logic [2:0] STATE;
   logic       READY;
   logic       LOCKOUT;

   modport master (
      input  ENABLE, TARGET_PWM, RAMP_STEP, RAMP_CYCLES, BBM_CFG, PRESCALER_CFG,
             RETRY_LIMIT, CYCLE, FAULT_DETECT, LIMIT_PWM,
      output DRV_RESET_n, PWM, BREAK_BEFORE_MAKE, PRESCALER, STATE, READY, LOCKOUT
   );

   modport slave (
      output ENABLE, TARGET_PWM, RAMP_STEP, RAMP_CYCLES, BBM_CFG, PRESCALER_CFG,
             RETRY_LIMIT, CYCLE, FAULT_DETECT, LIMIT_PWM,
      input  DRV_RESET_n, PWM, BREAK_BEFORE_MAKE, PRESCALER, STATE, READY, LOCKOUT
   );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Purpose: soft-start / fault-retry supervisor for a PWM driver. Ramps the
//          duty toward TARGET_PWM in steps paced by the driver's CYCLE pulse,
//          folds back on I/V limit events, and retries a faulted driver up to
//          RETRY_LIMIT times before locking out.
// Ports:
//   CLK      - clock, rising edge
//   RESET_n  - synchronous active-low reset
//   bus      - pwm_ramp_sequencer_if.master (config/status in, driver control out)
// Parameters:
//   RETRY_WAIT - CLK cycles the driver is held in reset between retries
module pwm_ramp_sequencer #(
   parameter int unsigned RETRY_WAIT = 16
) (
   input logic                  CLK,
   input logic                  RESET_n,
   pwm_ramp_sequencer_if.master bus
);

   localparam int unsigned WAIT_W    = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;
   localparam int unsigned WAIT_LAST = (RETRY_WAIT > 0) ? RETRY_WAIT - 1 : 0;
   localparam int unsigned RUN_W     = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RAMP  = 3'd1,
      S_RUN   = 3'd2,
      S_FAULT = 3'd3,
      S_RETRY = 3'd4,
      S_LOCK  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          pwm_q, pwm_d;
   logic                drv_q, drv_d;
   logic [3:0]          bbm_q, bbm_d;
   logic [2:0]          presc_q, presc_d;
   logic                ready_q, lockout_q;
   logic [3:0]          ramp_cnt_q, ramp_cnt_d;
   logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
   logic [1:0]          retry_q, retry_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;

   // Zero-valued step/cycle settings behave as 1
   logic [3:0] eff_step, eff_cycles;
   logic [4:0] ramp_cnt_inc;
   logic       ramp_hit;
   logic [8:0] ramp_sum;
   logic [7:0] ramp_pwm;

   assign eff_step     = (bus.RAMP_STEP   == 4'd0) ? 4'd1 : bus.RAMP_STEP;
   assign eff_cycles   = (bus.RAMP_CYCLES == 4'd0) ? 4'd1 : bus.RAMP_CYCLES;
   assign ramp_cnt_inc = 5'(ramp_cnt_q) + 5'd1;
   assign ramp_hit     = (ramp_cnt_inc == 5'(eff_cycles));
   // 9-bit sum so a large step near 255 saturates at the target instead of wrapping
   assign ramp_sum     = 9'(pwm_q) + 9'(eff_step);
   assign ramp_pwm     = (ramp_sum > 9'(bus.TARGET_PWM)) ? bus.TARGET_PWM : ramp_sum[7:0];

   // State and output registers
   always_ff @(posedge CLK) begin
      if (!RESET_n) begin
         state_q    <= S_IDLE;
         pwm_q      <= 8'd0;
         drv_q      <= 1'b0;
         bbm_q      <= 4'hF;
         presc_q    <= 3'd0;
         ready_q    <= 1'b0;
         lockout_q  <= 1'b0;
         ramp_cnt_q <= 4'd0;
         run_cnt_q  <= '0;
         retry_q    <= 2'd0;
         wait_q     <= '0;
      end else begin
         state_q    <= state_d;
         pwm_q      <= pwm_d;
         drv_q      <= drv_d;
         bbm_q      <= bbm_d;
         presc_q    <= presc_d;
         ready_q    <= (state_d == S_RUN);
         lockout_q  <= (state_d == S_LOCK);
         ramp_cnt_q <= ramp_cnt_d;
         run_cnt_q  <= run_cnt_d;
         retry_q    <= retry_d;
         wait_q     <= wait_d;
      end
   end

   // Next-state and next-output logic; priority is
   // ENABLE low > fault > limit fold-back > target decrease > ramp step
   always_comb begin
      state_d    = state_q;
      pwm_d      = pwm_q;
      drv_d      = drv_q;
      bbm_d      = bbm_q;
      presc_d    = presc_q;
      ramp_cnt_d = ramp_cnt_q;
      run_cnt_d  = run_cnt_q;
      retry_d    = retry_q;
      wait_d     = wait_q;

      case (state_q)
         S_IDLE: begin
            pwm_d   = 8'd0;
            drv_d   = 1'b0;
            retry_d = 2'd0;
            bbm_d   = bus.BBM_CFG;
            presc_d = bus.PRESCALER_CFG;
            if (bus.ENABLE) begin
               state_d    = S_RAMP;
               drv_d      = 1'b1;
               ramp_cnt_d = 4'd0;
            end
         end

         S_RAMP, S_RUN: begin
            if (!bus.ENABLE) begin
               state_d = S_IDLE;
               pwm_d   = 8'd0;
               drv_d   = 1'b0;
            end else if (bus.FAULT_DETECT) begin
               state_d = S_FAULT;
               pwm_d   = 8'd0;
            end else if (bus.CYCLE && (bus.LIMIT_PWM < pwm_q)) begin
               state_d    = S_RAMP;
               pwm_d      = bus.LIMIT_PWM;
               ramp_cnt_d = 4'd0;
            end else if (bus.TARGET_PWM < pwm_q) begin
               pwm_d = bus.TARGET_PWM;
            end else if (state_q == S_RUN) begin
               if (bus.TARGET_PWM > pwm_q) begin
                  state_d    = S_RAMP;
                  ramp_cnt_d = 4'd0;
               end
            end else if (bus.TARGET_PWM == pwm_q) begin
               state_d = S_RUN;
            end else if (bus.CYCLE) begin
               if (ramp_hit) begin
                  pwm_d      = ramp_pwm;
                  ramp_cnt_d = 4'd0;
               end else begin
                  ramp_cnt_d = ramp_cnt_inc[3:0];
               end
            end
         end

         // Single-clock decision point between another retry and lockout
         S_FAULT: begin
            if (!bus.ENABLE) begin
               state_d = S_IDLE;
               pwm_d   = 8'd0;
               drv_d   = 1'b0;
            end else if (retry_q == bus.RETRY_LIMIT) begin
               state_d = S_LOCK;
               pwm_d   = 8'd0;
               drv_d   = 1'b0;
            end else begin
               state_d = S_RETRY;
               retry_d = retry_q + 2'd1;
               drv_d   = 1'b0;
               wait_d  = '0;
            end
         end

         // Driver held in reset for RETRY_WAIT clocks, then a fresh ramp from 0
         S_RETRY: begin
            if (!bus.ENABLE) begin
               state_d = S_IDLE;
               pwm_d   = 8'd0;
               drv_d   = 1'b0;
            end else if (wait_q == WAIT_W'(WAIT_LAST)) begin
               state_d    = S_RAMP;
               drv_d      = 1'b1;
               pwm_d      = 8'd0;
               ramp_cnt_d = 4'd0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         S_LOCK: begin
            pwm_d = 8'd0;
            drv_d = 1'b0;
            if (!bus.ENABLE) state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            pwm_d   = 8'd0;
            drv_d   = 1'b0;
         end
      endcase

      // Sustained healthy running forgives earlier retries
      if (state_d != S_RUN) begin
         run_cnt_d = '0;
      end else if ((state_q == S_RUN) && bus.CYCLE) begin
         if (run_cnt_q == RUN_W'(15)) begin
            run_cnt_d = '0;
            retry_d   = 2'd0;
         end else begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
         end
      end
   end

   assign bus.STATE             = state_q;
   assign bus.PWM               = pwm_q;
   assign bus.DRV_RESET_n       = drv_q;
   assign bus.BREAK_BEFORE_MAKE = bbm_q;
   assign bus.PRESCALER         = presc_q;
   assign bus.READY             = ready_q;
   assign bus.LOCKOUT           = lockout_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Purpose: self-checking bench for pwm_ramp_sequencer. A table of per-clock
//          {inputs, expected outputs} rows covers ramping, saturation, target
//          changes and fold-back; hand-written sequences cover retry/lockout,
//          run-time retry forgiveness, config freezing and mid-retry reset.
module tb_pwm_ramp_sequencer;

   logic CLK;
   logic RESET_n;
   int   n_total;
   int   n_pass;

   pwm_ramp_sequencer_if bus();

   pwm_ramp_sequencer #(.RETRY_WAIT(16)) dut (
      .CLK     (CLK),
      .RESET_n (RESET_n),
      .bus     (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       en;
      logic [7:0] tgt;
      logic [3:0] stp;
      logic [3:0] rc;
      logic       cyc;
      logic [7:0] lim;
      logic [2:0] e_state;
      logic [7:0] e_pwm;
      logic       e_drv;
      logic       e_rdy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic en, input logic [7:0] tgt, input logic [3:0] stp,
                      input logic [3:0] rc, input logic cyc, input logic [7:0] lim,
                      input logic [2:0] st, input logic [7:0] pwm,
                      input logic drv, input logic rdy);
      vec_t v;
      v.en = en; v.tgt = tgt; v.stp = stp; v.rc = rc; v.cyc = cyc; v.lim = lim;
      v.e_state = st; v.e_pwm = pwm; v.e_drv = drv; v.e_rdy = rdy;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic run_until(input logic [2:0] st, input int budget, input string name);
      int n;
      n = 0;
      while (bus.STATE != st && n < budget) begin
         tick();
         n++;
      end
      check(name, int'(bus.STATE), int'(st));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int low_cnt;
      n_total = 0;
      n_pass  = 0;

      RESET_n              = 1'b0;
      bus.ENABLE           = 1'b0;
      bus.TARGET_PWM       = 8'd0;
      bus.RAMP_STEP        = 4'd0;
      bus.RAMP_CYCLES      = 4'd0;
      bus.BBM_CFG          = 4'd5;
      bus.PRESCALER_CFG    = 3'd3;
      bus.RETRY_LIMIT      = 2'd1;
      bus.CYCLE            = 1'b0;
      bus.FAULT_DETECT     = 1'b0;
      bus.LIMIT_PWM        = 8'hFF;
      tick();
      tick();
      check("reset state",   int'(bus.STATE), 0);
      check("reset pwm",     int'(bus.PWM), 0);
      check("reset drv",     int'(bus.DRV_RESET_n), 0);
      check("reset bbm",     int'(bus.BREAK_BEFORE_MAKE), 15);
      check("reset presc",   int'(bus.PRESCALER), 0);
      check("reset ready",   int'(bus.READY), 0);
      check("reset lockout", int'(bus.LOCKOUT), 0);
      RESET_n = 1'b1;

      // Ramp 0..40 by 8 every 2nd CYCLE, then RUN
      add(1,40,8,2,0,8'hFF, 1, 0,1,0);
      add(1,40,8,2,1,8'hFF, 1, 0,1,0);
      add(1,40,8,2,0,8'hFF, 1, 0,1,0);
      add(1,40,8,2,1,8'hFF, 1, 8,1,0);
      add(1,40,8,2,1,8'hFF, 1, 8,1,0);
      add(1,40,8,2,1,8'hFF, 1,16,1,0);
      add(1,40,8,2,1,8'hFF, 1,16,1,0);
      add(1,40,8,2,1,8'hFF, 1,24,1,0);
      add(1,40,8,2,1,8'hFF, 1,24,1,0);
      add(1,40,8,2,1,8'hFF, 1,32,1,0);
      add(1,40,8,2,1,8'hFF, 1,32,1,0);
      add(1,40,8,2,1,8'hFF, 1,40,1,0);
      add(1,40,8,2,0,8'hFF, 2,40,1,1);
      add(1,40,8,2,0,8'hFF, 2,40,1,1);
      // Target decrease in RUN, then increase back to RAMP
      add(1,30,8,2,0,8'hFF, 2,30,1,1);
      add(1,34,8,2,0,8'hFF, 1,30,1,0);
      add(1,34,8,2,1,8'hFF, 1,30,1,0);
      add(1,34,8,2,1,8'hFF, 1,34,1,0);
      add(1,34,8,2,0,8'hFF, 2,34,1,1);
      // Limit fold-back from RUN, then re-ramp
      add(1,34,8,2,1,8'd20, 1,20,1,0);
      add(1,34,8,2,1,8'hFF, 1,20,1,0);
      add(1,34,8,2,1,8'hFF, 1,28,1,0);
      add(1,34,8,2,1,8'hFF, 1,28,1,0);
      add(1,34,8,2,1,8'hFF, 1,34,1,0);
      add(1,34,8,2,0,8'hFF, 2,34,1,1);
      add(0,34,8,2,0,8'hFF, 0, 0,0,0);
      // Step 15, RAMP_CYCLES 0 -> saturates at 37
      add(1,37,15,0,0,8'hFF, 1, 0,1,0);
      add(1,37,15,0,1,8'hFF, 1,15,1,0);
      add(1,37,15,0,1,8'hFF, 1,30,1,0);
      add(1,37,15,0,1,8'hFF, 1,37,1,0);
      add(1,37,15,0,0,8'hFF, 2,37,1,1);
      add(0,37,15,0,0,8'hFF, 0, 0,0,0);
      // Step 0 behaves as +1 per CYCLE
      add(1,3,0,0,0,8'hFF, 1,0,1,0);
      add(1,3,0,0,1,8'hFF, 1,1,1,0);
      add(1,3,0,0,1,8'hFF, 1,2,1,0);
      add(1,3,0,0,1,8'hFF, 1,3,1,0);
      add(1,3,0,0,0,8'hFF, 2,3,1,1);
      add(0,3,0,0,0,8'hFF, 0,0,0,0);
      // Target 0 goes straight to RUN
      add(1,0,8,2,0,8'hFF, 1,0,1,0);
      add(1,0,8,2,0,8'hFF, 2,0,1,1);
      add(0,0,8,2,0,8'hFF, 0,0,0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         bus.ENABLE      = vecs[i].en;
         bus.TARGET_PWM  = vecs[i].tgt;
         bus.RAMP_STEP   = vecs[i].stp;
         bus.RAMP_CYCLES = vecs[i].rc;
         bus.CYCLE       = vecs[i].cyc;
         bus.LIMIT_PWM   = vecs[i].lim;
         tick();
         check($sformatf("row%0d state", i), int'(bus.STATE), int'(vecs[i].e_state));
         check($sformatf("row%0d pwm", i),   int'(bus.PWM), int'(vecs[i].e_pwm));
         check($sformatf("row%0d drv", i),   int'(bus.DRV_RESET_n), int'(vecs[i].e_drv));
         check($sformatf("row%0d ready", i), int'(bus.READY), int'(vecs[i].e_rdy));
      end
      bus.CYCLE = 1'b0;
      bus.LIMIT_PWM = 8'hFF;

      // Config tracks in IDLE, frozen otherwise
      check("idle bbm", int'(bus.BREAK_BEFORE_MAKE), 5);
      check("idle presc", int'(bus.PRESCALER), 3);
      bus.ENABLE = 1'b1; bus.TARGET_PWM = 8'd50; bus.RAMP_STEP = 4'd1; bus.RAMP_CYCLES = 4'd1;
      tick();
      bus.BBM_CFG = 4'd9; bus.PRESCALER_CFG = 3'd6;
      tick();
      check("frozen bbm", int'(bus.BREAK_BEFORE_MAKE), 5);
      check("frozen presc", int'(bus.PRESCALER), 3);
      bus.ENABLE = 1'b0;
      tick();
      tick();
      check("reload bbm", int'(bus.BREAK_BEFORE_MAKE), 9);
      check("reload presc", int'(bus.PRESCALER), 6);

      // RUN at 200, fold back to 90 on limit, ramp back to 200
      bus.ENABLE = 1'b1; bus.TARGET_PWM = 8'd200; bus.RAMP_STEP = 4'd15;
      bus.RAMP_CYCLES = 4'd1; bus.CYCLE = 1'b1;
      run_until(3'd2, 60, "ramp to 200 state");
      check("ramp to 200 pwm", int'(bus.PWM), 200);
      bus.LIMIT_PWM = 8'd90;
      tick();
      check("foldback pwm", int'(bus.PWM), 90);
      check("foldback state", int'(bus.STATE), 1);
      bus.LIMIT_PWM = 8'hFF;
      run_until(3'd2, 60, "reramp state");
      check("reramp pwm", int'(bus.PWM), 200);
      bus.CYCLE = 1'b0; bus.ENABLE = 1'b0;
      tick();

      // ENABLE low wins over FAULT_DETECT in RUN
      bus.ENABLE = 1'b1; bus.TARGET_PWM = 8'd10; bus.RAMP_STEP = 4'd15; bus.RAMP_CYCLES = 4'd1;
      tick();
      bus.CYCLE = 1'b1;
      tick();
      bus.CYCLE = 1'b0;
      tick();
      check("pre-priority state", int'(bus.STATE), 2);
      bus.ENABLE = 1'b0; bus.FAULT_DETECT = 1'b1;
      tick();
      check("priority state", int'(bus.STATE), 0);
      check("priority pwm", int'(bus.PWM), 0);
      bus.FAULT_DETECT = 1'b0;
      tick();

      // Fault retry then lockout with RETRY_LIMIT=1 and fault held
      bus.RETRY_LIMIT = 2'd1; bus.ENABLE = 1'b1; bus.TARGET_PWM = 8'd50;
      bus.RAMP_STEP = 4'd8; bus.RAMP_CYCLES = 4'd1;
      tick();
      bus.FAULT_DETECT = 1'b1;
      tick();
      check("fault1 state", int'(bus.STATE), 3);
      check("fault1 pwm", int'(bus.PWM), 0);
      low_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.DRV_RESET_n == 1'b0 && bus.STATE == 3'd4) low_cnt++;
         else break;
      end
      check("retry low clocks", low_cnt, 16);
      check("after retry state", int'(bus.STATE), 1);
      check("after retry drv", int'(bus.DRV_RESET_n), 1);
      tick();
      check("fault2 state", int'(bus.STATE), 3);
      tick();
      check("lock state", int'(bus.STATE), 5);
      check("lock lockout", int'(bus.LOCKOUT), 1);
      check("lock drv", int'(bus.DRV_RESET_n), 0);
      bus.FAULT_DETECT = 1'b0;
      tick();
      tick();
      check("lock held", int'(bus.LOCKOUT), 1);
      bus.ENABLE = 1'b0;
      tick();
      check("unlock state", int'(bus.STATE), 0);
      check("unlock lockout", int'(bus.LOCKOUT), 0);

      // 16 CYCLE pulses in RUN clear the retry count, so a new fault retries
      bus.ENABLE = 1'b1; bus.TARGET_PWM = 8'd8; bus.RAMP_STEP = 4'd8; bus.RAMP_CYCLES = 4'd1;
      tick();
      bus.FAULT_DETECT = 1'b1;
      tick();
      bus.FAULT_DETECT = 1'b0;
      run_until(3'd1, 40, "forgive reramp state");
      bus.CYCLE = 1'b1;
      tick();
      bus.CYCLE = 1'b0;
      tick();
      check("forgive run state", int'(bus.STATE), 2);
      bus.CYCLE = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      bus.CYCLE = 1'b0;
      bus.FAULT_DETECT = 1'b1;
      tick();
      tick();
      check("forgive retry state", int'(bus.STATE), 4);
      bus.FAULT_DETECT = 1'b0; bus.ENABLE = 1'b0;
      tick();

      // Reset in the middle of RETRY
      bus.ENABLE = 1'b1; bus.FAULT_DETECT = 1'b1; bus.TARGET_PWM = 8'd50;
      tick();
      tick();
      tick();
      tick();
      tick();
      check("pre-reset state", int'(bus.STATE), 4);
      RESET_n = 1'b0;
      tick();
      check("midreset state", int'(bus.STATE), 0);
      check("midreset pwm", int'(bus.PWM), 0);
      check("midreset drv", int'(bus.DRV_RESET_n), 0);
      check("midreset bbm", int'(bus.BREAK_BEFORE_MAKE), 15);
      check("midreset presc", int'(bus.PRESCALER), 0);
      check("midreset ready", int'(bus.READY), 0);
      check("midreset lockout", int'(bus.LOCKOUT), 0);
      RESET_n = 1'b1; bus.FAULT_DETECT = 1'b0;
      tick();
      check("post-reset state", int'(bus.STATE), 1);
      check("post-reset drv", int'(bus.DRV_RESET_n), 1);
      check("post-reset bbm", int'(bus.BREAK_BEFORE_MAKE), 9);
      bus.ENABLE = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
